// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed 4-digit FND scan driver with dead-time blanking,
// leading-zero suppression and frame-synchronous display updates.
module fnd_scan_controller #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 4_000,
    parameter int DEAD_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic [15:0] i_bcd,
    input  logic        i_load,
    input  logic [3:0]  i_dp,
    input  logic        i_lzBlank,
    output logic [1:0]  o_digitSelect,
    output logic        o_blank,
    output logic [7:0]  o_font,
    output logic        o_frame
);
    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [7:0] FONT_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {IDLE, DEAD, SHOW} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [15:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic          blank_q, blank_d, frame_q, frame_d;
    logic [7:0]    font_q, font_d;
    logic [3:0]    digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h40;
        endcase
    endfunction

    // A digit is suppressed only if it and every digit to its left are zero; d0 always shows.
    function automatic logic lz_hide(input logic [1:0] idx, input logic [15:0] bcd);
        logic z3, z2, z1;
        z3 = bcd[15:12] == 4'd0;
        z2 = z3 && bcd[11:8] == 4'd0;
        z1 = z2 && bcd[7:4] == 4'd0;
        return idx == 2'd3 ? z3 : idx == 2'd2 ? z2 : idx == 2'd1 ? z1 : 1'b0;
    endfunction

    always_comb begin
        shadow_d    = i_load ? i_bcd : shadow_q;
        shadow_dp_d = i_load ? i_dp : shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        state_d     = state_q;
        idx_d       = idx_q;
        presc_d     = presc_q + 1'b1;
        dead_d      = dead_q;
        frame_d     = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            presc_d = '0;
            dead_d  = '0;
        end else if (state_q == IDLE || presc_q == LAST_TICK) begin
            state_d = DEAD;
            idx_d   = state_q == IDLE ? 2'd0 : idx_q + 2'd1;
            presc_d = '0;
            dead_d  = DEAD_LOAD;
            frame_d = idx_d == 2'd0;
            // shadow_d already folds in a same-cycle load, so the newest digits win
            if (frame_d) begin
                disp_d    = shadow_d;
                disp_dp_d = shadow_dp_d;
            end
        end else if (state_q == DEAD) begin
            state_d = dead_q == '0 ? SHOW : DEAD;
            dead_d  = dead_q == '0 ? '0 : dead_q - 1'b1;
        end
        digit   = disp_d[{idx_d, 2'b00} +: 4];
        font_d  = !i_en ? FONT_OFF : {disp_dp_d[idx_d], seg7(digit)} ^ FONT_OFF;
        blank_d = state_d != SHOW || (i_lzBlank && lz_hide(idx_d, disp_d));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            presc_q     <= '0;
            dead_q      <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            blank_q     <= 1'b1;
            font_q      <= FONT_OFF;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            dead_q      <= dead_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            blank_q     <= blank_d;
            font_q      <= font_d;
            frame_q     <= frame_d;
        end
    end

    assign o_digitSelect = idx_q;
    assign o_blank       = blank_q;
    assign o_font        = font_q;
    assign o_frame       = frame_q;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: directed bench for the FND scan driver with 10-cycle slots
// and 2-cycle dead time, segments active-low.
module tb_fnd_scan_controller;
    logic        clk = 1'b0, rst_n, en = 1'b0, load = 1'b0, lz = 1'b0;
    logic [15:0] bcd = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [1:0]  sel;
    logic        blank, frame;
    logic [7:0]  font;
    int          checks = 0, failures = 0, ph = -1;
    logic [7:0]  exp_font [4];
    logic [3:0]  exp_hide = 4'h0;

    fnd_scan_controller #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_bcd(bcd), .i_load(load),
        .i_dp(dp), .i_lzBlank(lz), .o_digitSelect(sel), .o_blank(blank),
        .o_font(font), .o_frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_blank"}, blank, 1);
        chk({tag, "_font"}, font, 8'hFF);
        chk({tag, "_frame"}, frame, 0);
    endtask

    task automatic idle(input string tag);
        @(posedge clk);
        #1;
        chk_off(tag);
    endtask

    // Each slot is 10 cycles: 2 blank dead cycles, then 8 shown unless the digit is suppressed.
    task automatic run(input int n);
        int slot, pos;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ph++;
            slot = (ph / 10) % 4;
            pos  = ph % 10;
            chk($sformatf("sel@%0d", ph), sel, slot);
            chk($sformatf("blank@%0d", ph), blank, (pos < 2 || exp_hide[slot]) ? 1 : 0);
            chk($sformatf("font@%0d", ph), font, exp_font[slot]);
            chk($sformatf("frame@%0d", ph), frame, (pos == 0 && slot == 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_off("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle("idle_en0");

        bcd = 16'h1234; dp = 4'h0; load = 1'b1; en = 1'b1;
        exp_font = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        exp_hide = 4'h0;
        run(1);
        load = 1'b0;
        run(55);
        bcd = 16'h5678; load = 1'b1;
        run(1);
        load = 1'b0;
        run(23);
        exp_font = '{8'h80, 8'hF8, 8'h82, 8'h92};
        run(40);

        lz = 1'b1; bcd = 16'h0007; dp = 4'b1000; load = 1'b1;
        exp_font = '{8'hF8, 8'hC0, 8'hC0, 8'h40};
        exp_hide = 4'b1110;
        run(1);
        load = 1'b0;
        run(39);

        bcd = 16'h00A0; dp = 4'h0; load = 1'b1;
        exp_font = '{8'hC0, 8'hBF, 8'hC0, 8'hC0};
        exp_hide = 4'b1100;
        run(1);
        load = 1'b0;
        run(25);

        en = 1'b0;
        for (int i = 0; i < 3; i++) idle("idle_midslot");
        en = 1'b1;
        ph = -1;
        run(15);

        #2 rst_n = 1'b0;
        #1 chk_off("async_reset");
        #2 rst_n = 1'b1;
        exp_font = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
        exp_hide = 4'b1110;
        ph = -1;
        run(40);
        lz = 1'b0;
        exp_hide = 4'h0;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
